uart_16550_rx: RTL
==================

# uart_16550_rx

Receive path for the 16550-compatible UART: samples the `uart_rx` pin at 16x the baud rate, frames 8N1 characters, and queues them with per-character error flags in a first-word-fall-through FIFO. The register front end reads this FIFO for RBR and derives LSR[0], LSR[1], LSR[3] and LSR[4] from its outputs. The front end supplies `baud_divisor`, the same {DLM, DLL} value the transmitter uses.

## Interface
- `DEPTH`, default 16: FIFO entries; power of two, minimum 2.
- `clk`  input  1  clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `uart_rx`  input  1  serial pin; asynchronous; idles high.
- `baud_divisor`  input  16  clk cycles per 1/16 bit; a value of 0 is treated as 1.
- `rd_pop`  input  1  removes the FIFO head; ignored when `rd_valid`=0.
- `fifo_clr`  input  1  flushes the FIFO (FCR[1]).
- `err_clr`  input  1  clears `overrun_err` (pulsed when LSR is read).
- `rd_valid`  output  1  FIFO is not empty (LSR[0] DR).
- `rd_data`  output  8  head character; 0 when empty.
- `rd_fe`  output  1  framing error of the head character; 0 when empty.
- `rd_bi`  output  1  break indication of the head character; 0 when empty.
- `overrun_err`  output  1  sticky; a character was dropped because the FIFO was full.
- `fifo_count`  output  $clog2(DEPTH+1)  number of occupied entries.
- `rx_busy`  output  1  FSM is not in IDLE.

## Operation
- Synchronizer: two flops on `uart_rx`, both reset to 1. All logic below uses only the synchronized value `rxs`.
- Tick generator: a 16-bit down-counter reloads with max(`baud_divisor`,1) and emits a 1-clk `tick` when it reaches 1.
  - It is forced to reload when the FSM leaves IDLE, so that the first tick is phase-aligned to the start edge.
  - A change to `baud_divisor` takes effect at the next reload. The frame in progress may be corrupted but the FSM must not lock up.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. A 4-bit `tcnt` counts ticks; a 3-bit `bidx` counts bits.
  - IDLE: when `rxs`=0, go to START with `tcnt`=0.
  - START: on the 8th tick (mid start bit), sample `rxs`. If 0, go to DATA with `tcnt`=0 and `bidx`=0. If 1, the low pulse was a glitch: return to IDLE and push nothing.
  - DATA: on every 16th tick, sample `rxs` and shift it in LSB-first (shift right, insert at bit 7). After `bidx`=7, go to STOP.
  - STOP: on the 16th tick, sample `rxs`.
    - If 1: push {data, fe=0, bi=0} and go to IDLE.
    - If 0: push {data, fe=1, bi=(data==0)} and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1, then go to IDLE. A continuous break therefore yields exactly one entry.
- FIFO storage: DEPTH x 10 bits, with binary read/write pointers that wrap modulo DEPTH.
  - `rd_data`, `rd_fe` and `rd_bi` are combinational from the head entry, gated to 0 when empty.
- Event priority within one cycle:
  - `fifo_clr` beats a same-cycle push and pop: count goes to 0 and the push is discarded. `overrun_err` is unaffected.
  - Push while full without a pop: the character is dropped and `overrun_err` is set. FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both take effect, the count stays DEPTH, no overrun.
  - Push and pop in the same cycle while empty: the push is accepted, the pop is ignored, count becomes 1.
  - `err_clr` in the same cycle as an overrun event: set wins.
- `rd_pop` when empty: no effect.

## Timing
- Reset values: all outputs 0 and FIFO empty; FSM in IDLE; tick counter loaded; synchronizer flops at 1.
- A push registers at the clk edge of the stop-bit sample tick. `rd_valid` and `fifo_count` update at that same edge, i.e. they are visible on the next cycle.
- Latency, with D = max(`baud_divisor`,1), from the pin falling edge to `rd_valid`=1: between 152·D+2 and 152·D+D+3 clk cycles.
- After a stop sample of 1, the FSM re-arms in IDLE on the following clk, so back-to-back frames with no idle gap are received.
- `rd_pop` has effect at its clock edge. The next head entry appears on the following cycle; there are no wait states.
- Reset asserted mid-frame: the partial character is discarded, the FIFO is emptied, and all flags clear immediately (asynchronous).

## Test plan
- Nominal receive: D=1 (16 clk/bit), send 0x55, 8N1, stop=1. Expect `rd_valid`=1 with `rd_data`=0x55, `rd_fe`=0, `rd_bi`=0; latency within the bound. Then `rd_pop`: expect `rd_valid`=0 and `fifo_count`=0.
- Framing error and break:
  - Send 0xA3 with the stop bit driven 0. Expect an entry with data 0xA3 and fe=1.
  - Hold the line low for 30 bit times. Expect exactly one entry with data 0x00, fe=1, bi=1, and no further entries until the line returns high.
- Glitch rejection: at D=4, drive a low pulse of 5 ticks (20 clk). Expect no push, and `rx_busy` back to 0 by the 9th tick.
- Overrun: DEPTH=4, send 0x01 through 0x05 without popping. Expect `fifo_count`=4, `overrun_err`=1, and pops returning 0x01–0x04. A single `err_clr` then clears `overrun_err`.
- Simultaneous events:
  - With the FIFO full, pop in the same cycle as a push. Expect count to stay 4 and no overrun.
  - Assert `fifo_clr` in the same cycle as a push. Expect count 0.
- Reset mid-frame: assert `rst_n`=0 during data bit 4 of 0x5A. Expect all outputs 0. After release, send 0x3C and expect exactly one entry, 0x3C.

Source files
------------

// File: rtl/uart_16550_rx_if.sv
// Read-side bus between the UART receive FIFO and the 16550 register front end.
// The front end (master) pops/clears; the receiver (slave) presents the head entry and status.
interface uart_16550_rx_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          rd_pop;
  logic          fifo_clr;
  logic          err_clr;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic          rd_fe;
  logic          rd_bi;
  logic          overrun_err;
  logic [CW-1:0] fifo_count;

  modport master (
    output rd_pop, fifo_clr, err_clr,
    input  rd_valid, rd_data, rd_fe, rd_bi, overrun_err, fifo_count
  );

  modport slave (
    input  rd_pop, fifo_clr, err_clr,
    output rd_valid, rd_data, rd_fe, rd_bi, overrun_err, fifo_count
  );
endinterface

// File: rtl/uart_16550_rx.sv
// 16550-compatible receive path: 16x oversampled 8N1 framer feeding a
// first-word-fall-through FIFO of {bi, fe, data} entries.
module uart_16550_rx #(
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uart_rx,
  input  logic [15:0]           baud_divisor,
  output logic                  rx_busy,
  uart_16550_rx_if.slave        rx_if
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronizer; idles high so reset does not look like a start bit.
  // ---------------------------------------------------------------------------
  logic sync1;
  logic rxs;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rxs   <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // 16x tick generator
  // ---------------------------------------------------------------------------
  logic [15:0] div_eff;
  logic [15:0] tick_cnt;
  logic        tick;
  logic        tick_reload;

  assign div_eff = (baud_divisor == 16'd0) ? 16'd1 : baud_divisor;
  assign tick    = (tick_cnt == 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= 16'd1;
    end else if (tick_reload || tick_cnt <= 16'd1) begin
      tick_cnt <= div_eff;
    end else begin
      tick_cnt <= tick_cnt - 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] bidx_q, bidx_d;
  logic [7:0] shift_q, shift_d;
  logic       push;
  logic       push_fe;
  logic       push_bi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tcnt_q  <= 4'd0;
      bidx_q  <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    bidx_d      = bidx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    push_fe     = 1'b0;
    push_bi     = 1'b0;
    tick_reload = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d     = S_START;
          tcnt_d      = 4'd0;
          tick_reload = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if (tcnt_q == 4'd7) begin
            if (!rxs) begin
              state_d = S_DATA;
              tcnt_d  = 4'd0;
              bidx_d  = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          // tcnt wraps 15 -> 0, which is also the right start value for STOP.
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            shift_d = {rxs, shift_q[7:1]};
            bidx_d  = bidx_q + 3'd1;
            if (bidx_q == 3'd7) begin
              state_d = S_STOP;
            end
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            push = 1'b1;
            if (rxs) begin
              state_d = S_IDLE;
            end else begin
              push_fe = 1'b1;
              push_bi = (shift_q == 8'd0);
              state_d = S_WAIT_HIGH;
            end
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_busy = (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          overrun_set;
  logic          overrun_q;
  logic [9:0]    head;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign do_pop      = rx_if.rd_pop && !empty && !rx_if.fifo_clr;
  assign do_push     = push && (!full || do_pop) && !rx_if.fifo_clr;
  assign overrun_set = push && full && !do_pop && !rx_if.fifo_clr;

  // NOTE: the storage array has no reset; pointers and count alone define
  // which entries are valid, and empty-gating hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= {push_bi, push_fe, shift_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (rx_if.fifo_clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (overrun_set) begin
      overrun_q <= 1'b1;
    end else if (rx_if.err_clr) begin
      overrun_q <= 1'b0;
    end
  end

  assign head              = mem[rptr];
  assign rx_if.rd_valid    = !empty;
  assign rx_if.rd_data     = empty ? 8'd0 : head[7:0];
  assign rx_if.rd_fe       = empty ? 1'b0 : head[8];
  assign rx_if.rd_bi       = empty ? 1'b0 : head[9];
  assign rx_if.overrun_err = overrun_q;
  assign rx_if.fifo_count  = count;

endmodule
